// File: rtl/biu_pkg.sv
// Shared types and default decode windows for the bus interface unit.
package biu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } biu_state_e;

    localparam int ERR_CNT_W = 8;

    localparam int DEF_NSLV = 4;
    localparam int DEF_AW   = 32;

    // Slot i occupies the 4 KiB window starting at i*0x1000; slot 0 is in the low bits.
    localparam logic [DEF_NSLV*DEF_AW-1:0] DEF_BASE = {
        32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000
    };
    localparam logic [DEF_NSLV*DEF_AW-1:0] DEF_MASK = {DEF_NSLV{32'hFFFF_F000}};

endpackage

// File: rtl/biu_decode.sv
// Combinational address decoder: per-slot base/mask match, lowest index wins.
module biu_decode
    import biu_pkg::*;
#(
    parameter int                   NSLV = DEF_NSLV,
    parameter int                   AW   = DEF_AW,
    parameter int                   IDXW = (NSLV > 1) ? $clog2(NSLV) : 1,
    parameter logic [NSLV*AW-1:0]   BASE = DEF_BASE,
    parameter logic [NSLV*AW-1:0]   MASK = DEF_MASK
) (
    input  logic [AW-1:0]   addr_i,
    output logic [NSLV-1:0] sel_oh_o,
    output logic [IDXW-1:0] idx_o,
    output logic            hit_o
);

    logic [NSLV-1:0] hit_vec_s;
    logic            first_s;

    // Match every window, then keep only the first hit scanning upward.
    always_comb begin
        hit_vec_s = '0;
        sel_oh_o  = '0;
        idx_o     = '0;
        hit_o     = 1'b0;
        first_s   = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            hit_vec_s[i] = ((addr_i & MASK[i*AW +: AW]) == BASE[i*AW +: AW]);
        end
        for (int i = 0; i < NSLV; i++) begin
            first_s     = hit_vec_s[i] & ~hit_o;
            sel_oh_o[i] = first_s;
            idx_o       = first_s ? IDXW'(i) : idx_o;
            hit_o       = hit_o | hit_vec_s[i];
        end
    end

endmodule

// File: rtl/biu_mux.sv
// Bus interface unit routing one master port to NSLV slaves via req/ack.
// Optional bus-stall timeout is enabled by defining BIU_TIMEOUT_EN.
module biu_mux
    import biu_pkg::*;
#(
    parameter int                   NSLV    = DEF_NSLV,
    parameter int                   DW      = 32,
    parameter int                   AW      = DEF_AW,
    parameter logic [NSLV*AW-1:0]   BASE    = DEF_BASE,
    parameter logic [NSLV*AW-1:0]   MASK    = DEF_MASK,
    parameter int                   TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_req,
    input  logic [AW-1:0]           m_addr,
    input  logic [DW-1:0]           m_wdata,
    input  logic [DW/8-1:0]         m_we,
    output logic [DW-1:0]           m_rdata,
    output logic                    m_ack,
    output logic                    m_err,
    output logic [NSLV-1:0]         s_req,
    output logic [AW-1:0]           s_addr,
    output logic [DW-1:0]           s_wdata,
    output logic [NSLV*DW/8-1:0]    s_we,
    input  logic [NSLV*DW-1:0]      s_rdata,
    input  logic [NSLV-1:0]         s_ack,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output logic [AW-1:0]           err_addr
);

    localparam int BW   = DW / 8;
    localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

    if (NSLV < 1 || NSLV > 8) begin : g_bad_nslv
        $error("biu_mux: NSLV must be 1..8");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("biu_mux: DW must be a multiple of 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("biu_mux: TIMEOUT must be 1..255");
    end

    biu_state_e             state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [NSLV-1:0]        sel_q, sel_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [BW-1:0]          we_q, we_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [AW-1:0]          err_addr_q, err_addr_d;
`ifdef BIU_TIMEOUT_EN
    localparam logic [7:0]  TO_LIM = TIMEOUT[7:0];
    logic [7:0]             wait_q, wait_d;
`endif

    logic [NSLV-1:0]        dec_sel_s;
    logic [IDXW-1:0]        dec_idx_s;
    logic                   dec_hit_s;

    biu_decode #(
        .NSLV (NSLV),
        .AW   (AW),
        .IDXW (IDXW),
        .BASE (BASE),
        .MASK (MASK)
    ) u_decode (
        .addr_i   (m_addr),
        .sel_oh_o (dec_sel_s),
        .idx_o    (dec_idx_s),
        .hit_o    (dec_hit_s)
    );

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
`ifdef BIU_TIMEOUT_EN
            wait_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
`ifdef BIU_TIMEOUT_EN
            wait_q     <= wait_d;
`endif
        end
    end

    // Next-state and latch logic for the IDLE/BUSY/RESP sequence.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
`ifdef BIU_TIMEOUT_EN
        wait_d     = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    addr_d = m_addr;
                    if (dec_hit_s) begin
                        idx_d   = dec_idx_s;
                        sel_d   = dec_sel_s;
                        wdata_d = m_wdata;
                        we_d    = m_we;
                        err_d   = 1'b0;
`ifdef BIU_TIMEOUT_EN
                        wait_d  = 8'd0;
`endif
                        state_d = ST_BUSY;
                    end else begin
                        sel_d   = '0;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (s_ack[idx_q]) begin
                    rdata_d = s_rdata[int'(idx_q)*DW +: DW];
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
`ifdef BIU_TIMEOUT_EN
                    if (wait_q == TO_LIM) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        wait_d  = wait_q + 8'd1;
                        state_d = ST_BUSY;
                    end
`else
                    state_d = ST_BUSY;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (err_q) begin
                    err_addr_d = addr_q;
                    err_cnt_d  = (err_cnt_q == {ERR_CNT_W{1'b1}}) ? err_cnt_q
                                                                  : err_cnt_q + 8'd1;
                end else begin
                    err_addr_d = err_addr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs derive only from registered state, never from live inputs.
    always_comb begin
        s_req = '0;
        s_we  = '0;
        m_ack = 1'b0;
        m_err = 1'b0;
        case (state_q)
            ST_BUSY: begin
                s_req = sel_q;
                for (int i = 0; i < NSLV; i++) begin
                    s_we[i*BW +: BW] = sel_q[i] ? we_q : '0;
                end
            end
            ST_RESP: begin
                m_ack = 1'b1;
                m_err = err_q;
            end
            default: begin
                s_req = '0;
            end
        endcase
    end

    assign m_rdata  = rdata_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

endmodule

// File: doc/biu_mux.md
# biu_mux

Parametrised bus interface unit joining the core's single data port to NSLV memory-mapped slaves (DMEM, peripherals). Each transaction is decoded against per-slave base/mask windows and routed to exactly one slave with a req/ack handshake. Slaves may insert wait states. Unmapped addresses and (optionally) stalled slaves return a bus error instead of hanging the core.

## Interface
Parameters:
- NSLV, 4: number of slave ports, 1..8.
- DW, 32: data width, multiple of 8.
- AW, 32: address width.
- BASE, {NSLV x AW}: packed base addresses; slot 0 = 0x0000_0000, slot 1 = 0x0000_1000, etc. (slot i = i*0x1000).
- MASK, {NSLV x AW}: packed decode masks; default 0xFFFF_F000 for every slot.
- TIMEOUT, 15: maximum wait cycles before a timeout error, 1..255.

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- reset, in, 1: asynchronous, active-low; 0 = in reset.
- m_req, in, 1: master request; held with address and data stable until m_ack.
- m_addr, in, AW: byte address.
- m_wdata, in, DW: write data.
- m_we, in, DW/8: byte write enables; all zero means read.
- m_rdata, out, DW: registered read data, valid while m_ack=1.
- m_ack, out, 1: one-cycle completion pulse.
- m_err, out, 1: qualifies m_ack as an error response.
- s_req, out, NSLV: one-hot slave request.
- s_addr, out, AW: broadcast address.
- s_wdata, out, DW: broadcast write data.
- s_we, out, NSLV*DW/8: write enables; nonzero only for the selected slave.
- s_rdata, in, NSLV*DW: per-slave read data.
- s_ack, in, NSLV: per-slave completion; sampled only for the selected slave.
- err_cnt, out, 8: saturating count of error responses.
- err_addr, out, AW: address of the most recent error.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - On m_req=1, decode: slot i hits when (m_addr & MASK[i]) == BASE[i]. The lowest hitting index wins.
  - On a hit: latch the index, address, wdata and we; go to BUSY.
  - On a miss: go to RESP with the error flag set, and set rdata = 0.
- BUSY:
  - s_req[idx]=1. s_addr, s_wdata and s_we come from the latched registers.
  - On s_ack[idx]=1: capture s_rdata[idx] and go to RESP with no error.
  - Acks from non-selected slaves are ignored.
- RESP: m_ack=1 for exactly one cycle, m_err = latched error flag, then go to IDLE.
- On every error: err_cnt increments, saturating at 255, and err_addr is loaded with the latched address.
- Writes to unmapped addresses have no side effects; they return only an error.
- Outputs are pure functions of registered state. There are no combinational paths from m_* or s_* inputs to outputs.
- Reset values:
  - State IDLE.
  - m_ack, m_err, s_req, s_we, err_cnt = 0.
  - m_rdata, err_addr, s_addr, s_wdata = 0.
- Reset asserted mid-transaction aborts it immediately. No ack is issued, and the slave sees s_req drop asynchronously.

## Timing
- Master request is sampled on edge T.
- Zero-wait slave: the slave acks at T+1, so m_ack appears at T+2. Minimum read/write latency is 2 cycles.
- Each slave wait state adds one cycle.
- Miss: m_ack with m_err=1 at T+1.
- After RESP, the master must deassert m_req or present a new request. The FSM resamples m_req in the cycle after m_ack, giving a maximum throughput of one transaction per 3 cycles.
- m_req is ignored outside IDLE. Changing the address mid-transaction has no effect.

## Configuration
- BIU_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, the FSM goes to RESP with the error flag set and s_req drops.
  - An ack arriving in the same cycle as the timeout wins, giving a normal response.
- Not defined: the counter is absent and BUSY waits indefinitely.

## Structure
- biu_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - ERR_CNT_W = 8;
  - the default BASE/MASK constants.
- Sub-module biu_decode: a combinational address-to-one-hot decoder with priority selection and a hit flag, parametrised by NSLV, AW, BASE and MASK.

## Test plan
- Read slot 0 at 0x0000_0010 with s_ack[0] at T+1 and s_rdata[0]=0xDEADBEEF -> m_ack at T+2, m_rdata=0xDEADBEEF, m_err=0.
- Write 0xA5A5A5A5 to 0x0000_1004 with m_we=4'b0011 and slot 1 waiting 3 cycles -> s_we slice 1 = 0011, all other s_we slices 0, m_ack at T+5.
- Access 0x8000_0000 (unmapped) -> m_ack with m_err=1 at T+1, no s_req pulse, err_cnt=1, err_addr=0x8000_0000.
- With BIU_TIMEOUT_EN and TIMEOUT=15, slot 2 never acks -> m_err at T+17 (16 BUSY cycles); in a separate run, ack coinciding with the timeout cycle -> m_err=0.
- Reset driven low during BUSY -> s_req=0 immediately, no m_ack; after release, the next read completes normally.
- Issue 300 unmapped accesses -> err_cnt saturates at 255.
